// File: rtl/div_arbiter.sv
// ---------------------------------------------------------------------------
// div_arbiter
// Round-robin arbiter that hands one operand pair at a time from NUM_CH
// requesters to a single shared divider. It returns the quotient and
// remainder tagged with the channel index. If the divider does not answer
// within TIMEOUT cycles, the operation is aborted and reported with an error.
//
// Optional feature: define DIV_ARBITER_DIVZERO_EN to catch d == 0 locally.
// Such an operation then goes straight to DONE with q = all-ones, r = n and
// err = 1, and the divider is not started. Without the macro, d == 0 is sent
// to the divider like any other operand pair.
//
// Ports
//   clk_i, rst_n_i          clock; synchronous active-low reset
//   req_i  [NUM_CH]         per-channel request, held until ack
//   n_i, d_i               packed operands, channel k at [k*WIDTH +: WIDTH]
//   ack_o  [NUM_CH]         one-hot operand-accepted pulse
//   q_o, r_o, ch_o, err_o   result, held until the next result
//   val_o                   one-cycle result strobe
//   busy_o                  an operation is in progress
//   div_act_o, div_n_o, div_d_o   divider start pulse and operands
//   div_q_i, div_r_i, div_val_i   divider result and done strobe
//
// state | meaning
// IDLE  | waiting for a request; round-robin grant
// ISSUE | one-cycle start pulse to the divider; arm the timer
// WAIT  | waiting for the divider or for the timer to expire
// DONE  | result strobe; update round-robin pointer
// ---------------------------------------------------------------------------
module div_arbiter #(
    parameter int NUM_CH    = 4,
    parameter int WIDTH     = 48,
    parameter int PRECISION = 47,
    parameter int TIMEOUT   = 64
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic [NUM_CH-1:0]           req_i,
    input  logic [NUM_CH*WIDTH-1:0]     n_i,
    input  logic [NUM_CH*WIDTH-1:0]     d_i,
    output logic [NUM_CH-1:0]           ack_o,
    output logic [PRECISION:0]          q_o,
    output logic [WIDTH-1:0]            r_o,
    output logic [$clog2(NUM_CH)-1:0]   ch_o,
    output logic                        val_o,
    output logic                        err_o,
    output logic                        busy_o,
    output logic                        div_act_o,
    output logic [WIDTH-1:0]            div_n_o,
    output logic [WIDTH-1:0]            div_d_o,
    input  logic [PRECISION:0]          div_q_i,
    input  logic [WIDTH-1:0]            div_r_i,
    input  logic                        div_val_i
);

    localparam int CW = $clog2(NUM_CH);
    localparam int TW = $clog2(TIMEOUT);

`ifdef DIV_ARBITER_DIVZERO_EN
    localparam bit DIVZERO_EN = 1'b1;
`else
    localparam bit DIVZERO_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   last_grant;
    logic [CW-1:0]   grant;
    logic [CW-1:0]   pick;
    logic [TW-1:0]   timer;
    logic [WIDTH-1:0] sel_n;
    logic [WIDTH-1:0] sel_d;
    logic            sel_zero;

    // First requester strictly after 'last', wrapping. The loop runs from
    // the farthest offset to the nearest, so the nearest requester is
    // written last and wins.
    function automatic logic [CW-1:0] rr_pick(input logic [NUM_CH-1:0] req,
                                              input logic [CW-1:0]     last);
        logic [CW-1:0] p;
        int            c;
        p = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            c = (int'(last) + i) % NUM_CH;
            if (req[CW'(c)]) p = CW'(c);
        end
        return p;
    endfunction

    always_comb begin
        pick     = rr_pick(req_i, last_grant);
        sel_n    = n_i[int'(pick)*WIDTH +: WIDTH];
        sel_d    = d_i[int'(pick)*WIDTH +: WIDTH];
        sel_zero = (sel_d == '0);
    end

    always_comb begin
        state_nx  = state;
        busy_o    = (state != S_IDLE);
        div_act_o = (state == S_ISSUE);
        val_o     = (state == S_DONE);
        case (state)
            S_IDLE:  if (|req_i) state_nx = (DIVZERO_EN && sel_zero) ? S_DONE : S_ISSUE;
            S_ISSUE: state_nx = S_WAIT;
            S_WAIT:  if (div_val_i || timer == '0) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state      <= S_IDLE;
            last_grant <= CW'(NUM_CH - 1);
            grant      <= '0;
            timer      <= '0;
            ack_o      <= '0;
            q_o        <= '0;
            r_o        <= '0;
            ch_o       <= '0;
            err_o      <= 1'b0;
            div_n_o    <= '0;
            div_d_o    <= '0;
        end else begin
            state <= state_nx;
            ack_o <= '0;
            case (state)
                S_IDLE: begin
                    if (|req_i) begin
                        grant   <= pick;
                        div_n_o <= sel_n;
                        div_d_o <= sel_d;
                        ack_o   <= NUM_CH'(1) << pick;
                        if (DIVZERO_EN && sel_zero) begin
                            q_o   <= '1;
                            r_o   <= sel_n;
                            err_o <= 1'b1;
                            ch_o  <= pick;
                        end
                    end
                end
                // Down-counter: reaching zero marks TIMEOUT cycles spent in WAIT.
                S_ISSUE: timer <= TW'(TIMEOUT - 1);
                S_WAIT: begin
                    if (div_val_i) begin
                        q_o   <= div_q_i;
                        r_o   <= div_r_i;
                        err_o <= 1'b0;
                        ch_o  <= grant;
                    end else if (timer == '0) begin
                        q_o   <= '0;
                        r_o   <= '0;
                        err_o <= 1'b1;
                        ch_o  <= grant;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                S_DONE: last_grant <= grant;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_arbiter.sv
module tb_div_arbiter;

    localparam int NUM_CH    = 4;
    localparam int W         = 48;
    localparam int PRECISION = 47;
    localparam int PW        = PRECISION + 1;
    localparam int TIMEOUT   = 64;
    localparam int CW        = $clog2(NUM_CH);

`ifdef DIV_ARBITER_DIVZERO_EN
    localparam bit DZ = 1'b1;
`else
    localparam bit DZ = 1'b0;
`endif

    logic                    clk_i = 1'b0;
    logic                    rst_n_i;
    logic [NUM_CH-1:0]       req_i;
    logic [NUM_CH*W-1:0]     n_i, d_i;
    logic [NUM_CH-1:0]       ack_o;
    logic [PRECISION:0]      q_o;
    logic [W-1:0]            r_o;
    logic [CW-1:0]           ch_o;
    logic                    val_o, err_o, busy_o, div_act_o;
    logic [W-1:0]            div_n_o, div_d_o;
    logic [PRECISION:0]      div_q_i;
    logic [W-1:0]            div_r_i;
    logic                    div_val_i;

    div_arbiter #(.NUM_CH(NUM_CH), .WIDTH(W), .PRECISION(PRECISION), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .req_i(req_i), .n_i(n_i), .d_i(d_i),
        .ack_o(ack_o), .q_o(q_o), .r_o(r_o), .ch_o(ch_o), .val_o(val_o), .err_o(err_o),
        .busy_o(busy_o), .div_act_o(div_act_o), .div_n_o(div_n_o), .div_d_o(div_d_o),
        .div_q_i(div_q_i), .div_r_i(div_r_i), .div_val_i(div_val_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int               ch;
        logic [PW-1:0]    q;
        logic [W-1:0]     r;
        logic             err;
        logic             tmo;
    } exp_t;

    exp_t          expq[$];
    logic [W-1:0]  op_n [NUM_CH];
    logic [W-1:0]  op_d [NUM_CH];
    logic [W-1:0]  cur_n, cur_d;
    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    int            issue_cyc = 0;
    int            act_count = 0;
    int            div_lat = 1;
    int            lat_cnt = 0;
    bit            late_pulse = 0;
    bit            dv_prev = 0;
    int            ref_last = NUM_CH - 1;

    always_comb begin
        n_i = '0;
        d_i = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            n_i[k*W +: W] = op_n[k];
            d_i[k*W +: W] = op_d[k];
        end
    end

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [W-1:0] rnd48();
        return W'({$urandom(), $urandom()});
    endfunction

    // Round-robin reference: nearest requester after the last winner.
    function automatic int ref_pick(input logic [NUM_CH-1:0] mask);
        logic [NUM_CH-1:0] s;
        int idx;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = (ref_last + i) % NUM_CH;
            s = mask >> idx;
            if (s[0]) return idx;
        end
        return -1;
    endfunction

    // Divider model: answers 'div_lat' cycles after the start pulse (0 = never).
    initial begin
        div_val_i = 1'b0;
        div_q_i   = '0;
        div_r_i   = '0;
        forever begin
            logic [W-1:0] cn, cd;
            @(negedge clk_i);
            div_val_i = 1'b0;
            if (div_act_o && rst_n_i) begin
                act_count++;
                lat_cnt   = div_lat;
                cn        = div_n_o;
                cd        = div_d_o;
                issue_cyc = cyc;
            end else if (lat_cnt > 0) begin
                lat_cnt--;
                if (lat_cnt == 0) begin
                    chk("div_n_stable", 64'(div_n_o), 64'(cur_n));
                    chk("div_d_stable", 64'(div_d_o), 64'(cur_d));
                    div_val_i = 1'b1;
                    if (cd == '0) begin
                        div_q_i = '1;
                        div_r_i = cn;
                    end else begin
                        div_q_i = PW'(cn / cd);
                        div_r_i = cn % cd;
                    end
                end
            end
            if (late_pulse) begin
                late_pulse = 0;
                div_val_i  = 1'b1;
                div_q_i    = PW'(rnd48());
                div_r_i    = rnd48();
            end
        end
    end

    // Monitor: every result strobe is matched against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            #1;
            if (rst_n_i && val_o) begin
                if (expq.size() == 0) begin
                    chk("unexpected_val", 64'(val_o), 64'(0));
                end else begin
                    e = expq.pop_front();
                    chk("res_ch", 64'(ch_o), 64'(e.ch));
                    chk("res_q", 64'(q_o), 64'(e.q));
                    chk("res_r", 64'(r_o), 64'(e.r));
                    chk("res_err", 64'(err_o), 64'(e.err));
                    chk("val_after_div_val", 64'(dv_prev), 64'(!e.err));
                    if (e.tmo) chk("timeout_cycle", 64'(cyc), 64'(issue_cyc + 1 + TIMEOUT));
                end
            end
            dv_prev = div_val_i;
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        chk("busy_clears", 64'(busy_o), 64'(0));
    endtask

    task automatic run_txn(input logic [NUM_CH-1:0] mask, input int lat);
        exp_t e;
        int   ch;
        int   acts0;
        bit   zp;
        ch = ref_pick(mask);
        zp = DZ && (op_d[ch] == '0);
        e.ch  = ch;
        e.tmo = 1'b0;
        if (zp) begin
            e.q = '1; e.r = op_n[ch]; e.err = 1'b1;
        end else if (lat == 0) begin
            e.q = '0; e.r = '0; e.err = 1'b1; e.tmo = 1'b1;
        end else if (op_d[ch] == '0) begin
            e.q = '1; e.r = op_n[ch]; e.err = 1'b0;
        end else begin
            e.q = PW'(op_n[ch] / op_d[ch]); e.r = op_n[ch] % op_d[ch]; e.err = 1'b0;
        end
        cur_n   = op_n[ch];
        cur_d   = op_d[ch];
        expq.push_back(e);
        div_lat = lat;
        acts0   = act_count;
        req_i   = mask;
        @(negedge clk_i);
        chk("ack_onehot", 64'(ack_o), 64'(1) << ch);
        chk("div_act_with_ack", 64'(div_act_o), 64'(!zp));
        if (!zp) begin
            chk("div_n_issue", 64'(div_n_o), 64'(cur_n));
            chk("div_d_issue", 64'(div_d_o), 64'(cur_d));
        end
        req_i = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            op_n[k] = rnd48();
            op_d[k] = rnd48() | W'(1);
        end
        wait_idle();
        chk("div_act_count", 64'(act_count - acts0), 64'(!zp));
        chk("q_hold", 64'(q_o), 64'(e.q));
        chk("ch_hold", 64'(ch_o), 64'(ch));
        ref_last = ch;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NUM_CH-1:0] m;
        rst_n_i = 1'b0;
        req_i   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            op_n[k] = '0;
            op_d[k] = W'(1);
        end
        repeat (3) @(negedge clk_i);
        rst_n_i = 1'b1;
        chk("rst_ack", 64'(ack_o), 64'(0));
        chk("rst_val", 64'(val_o), 64'(0));
        chk("rst_err", 64'(err_o), 64'(0));
        chk("rst_busy", 64'(busy_o), 64'(0));
        chk("rst_div_act", 64'(div_act_o), 64'(0));
        chk("rst_q", 64'(q_o), 64'(0));
        chk("rst_r", 64'(r_o), 64'(0));
        chk("rst_ch", 64'(ch_o), 64'(0));
        chk("rst_div_n", 64'(div_n_o), 64'(0));
        chk("rst_div_d", 64'(div_d_o), 64'(0));

        // All channels requesting: grants must rotate 0,1,2,3,0.
        for (int i = 0; i < 5; i++) run_txn('1, int'($urandom_range(1, 20)));

        // Single request on channel 1 with a 48-cycle divider.
        op_n[1] = W'(6);
        op_d[1] = W'(3);
        run_txn(4'b0010, 48);

        // Divider never answers, then a late strobe must be ignored.
        run_txn(NUM_CH'($urandom_range(1, 15)), 0);
        late_pulse = 1;
        repeat (4) @(negedge clk_i);
        chk("late_val_busy", 64'(busy_o), 64'(0));

        // Zero denominator on channel 2.
        op_n[2] = W'(5);
        op_d[2] = '0;
        run_txn(4'b0100, 10);

        // Randomized traffic, including occasional timeouts.
        for (int i = 0; i < 20; i++) begin
            m = NUM_CH'($urandom_range(1, 15));
            for (int k = 0; k < NUM_CH; k++)
                op_d[k] = (rnd48() >> $urandom_range(47, 0)) | W'(1);
            run_txn(m, ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 60)));
        end

        // Reset in WAIT abandons the operation; channel 0 regains priority.
        div_lat = 0;
        req_i   = 4'b0010;
        @(negedge clk_i);
        chk("abort_ack", 64'(ack_o), 64'(4'b0010));
        req_i = '0;
        repeat (5) @(negedge clk_i);
        rst_n_i = 1'b0;
        @(negedge clk_i);
        rst_n_i = 1'b1;
        chk("abort_busy", 64'(busy_o), 64'(0));
        chk("abort_val", 64'(val_o), 64'(0));
        ref_last   = NUM_CH - 1;
        late_pulse = 1;
        repeat (4) @(negedge clk_i);
        chk("abort_late_busy", 64'(busy_o), 64'(0));
        run_txn('1, 5);

        repeat (5) @(negedge clk_i);
        chk("scoreboard_empty", 64'(expq.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_arbiter.md
DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 Parameter NUM_CH, default 4, number of requester channels (2..8).
REQ-002 Parameter WIDTH, default 48, numerator/denominator width.
REQ-003 Parameter PRECISION, default 47, quotient MSB index (quotient is PRECISION+1 bits).
REQ-004 Parameter TIMEOUT, default 64, max WAIT cycles before abort (greater than PRECISION+4).
REQ-005 clk_i  in  1  single clock; all logic on its rising edge.
REQ-006 rst_n_i  in  1  reset, synchronous, active-low.
REQ-007 req_i  in  NUM_CH  per-channel request, held until ack.
REQ-008 n_i  in  NUM_CH*WIDTH  per-channel numerator, channel k at bits [k*WIDTH +: WIDTH].
REQ-009 d_i  in  NUM_CH*WIDTH  per-channel denominator, same packing.
REQ-010 ack_o  out  NUM_CH  one-hot, one-cycle operand-accepted pulse.
REQ-011 q_o  out  PRECISION+1  result quotient; r_o  out  WIDTH  result remainder.
REQ-012 ch_o  out  clog2(NUM_CH)  channel index of the current result.
REQ-013 val_o  out  1  one-cycle result strobe; err_o  out  1  result-error flag, qualified by val_o.
REQ-014 busy_o  out  1  high whenever the state is not IDLE.
REQ-015 div_act_o  out  1, div_n_o  out  WIDTH, div_d_o  out  WIDTH: start pulse and operands to the shared divider.
REQ-016 div_q_i  in  PRECISION+1, div_r_i  in  WIDTH, div_val_i  in  1: divider result and done strobe.

Function
REQ-017 FSM states IDLE, ISSUE, WAIT, DONE; transitions occur only as stated below.
REQ-018 IDLE: if any req_i is high, grant the first requesting channel, searching round-robin from last_grant+1 upward with wrap to 0; latch its n and d; pulse ack_o[grant] in the next cycle; go to ISSUE.
REQ-019 IDLE with no request: remain in IDLE with all strobes low.
REQ-020 ISSUE: div_act_o=1 for exactly one cycle; div_n_o/div_d_o carry the latched operands, stable from ISSUE until leaving WAIT; clear the timer; go to WAIT.
REQ-021 WAIT: on div_val_i=1, capture div_q_i/div_r_i; err=0; go to DONE.
REQ-022 WAIT: when the timer reaches TIMEOUT-1 without div_val_i, go to DONE with q=0, r=0, err=1.
REQ-023 DONE: val_o=1 for one cycle; ch_o=grant; update last_grant=grant; go to IDLE.
REQ-024 q_o, r_o, ch_o and err_o hold their values until the next DONE.
REQ-025 Latency: request sampled at edge t gives ack_o in cycle t+1 and div_act_o in cycle t+1; val_o follows div_val_i by one cycle.
REQ-026 Ignore div_val_i in any state other than WAIT.
REQ-027 Ignore changes to req_i, n_i or d_i of the granted channel after ack; a request dropped before ack is withdrawn without side effects.
REQ-028 Only one operation is in flight; the divider is never restarted while busy_o=1.
REQ-029 Throughput: minimum of 4 cycles plus divider latency between accepts.

Reset
REQ-030 rst_n_i low at a clock edge: state=IDLE, last_grant=NUM_CH-1 (channel 0 has first priority), timer=0.
REQ-031 Reset values: ack_o, val_o, err_o, busy_o and div_act_o = 0; q_o, r_o, ch_o, div_n_o and div_d_o = 0.
REQ-032 Reset in ISSUE or WAIT abandons the operation, produces no val_o, and a late div_val_i is ignored per REQ-026.

Configuration
REQ-033 Macro DIV_ARBITER_DIVZERO_EN, when defined: a granted operation with d=0 goes IDLE->DONE directly; no div_act_o; q=all-ones, r=n, err=1; ack_o as usual.
REQ-034 Without the macro: d=0 is issued to the divider like any other operand and err reflects only the timeout.

Verification
REQ-035 Single request: ch1 n=6, d=3; divider model returns val after 48 cycles -> one ack_o[1], one div_act_o, val_o one cycle after div_val_i, ch_o=1, err_o=0.
REQ-036 Round robin: req_i=4'b1111 held and re-asserted after every ack -> grant order 0,1,2,3,0 with no starvation.
REQ-037 Timeout: divider never returns val -> val_o=1, err_o=1, q_o=0 exactly TIMEOUT cycles after WAIT entry; a late div_val_i is ignored.
REQ-038 Divide by zero, ch2 d=0, n=5: with macro -> no div_act_o, q_o=all-ones, r_o=5, err_o=1; without macro -> div_act_o issued with d=0.
REQ-039 Reset mid-WAIT, then div_val_i pulse -> no val_o, busy_o=0, and the next grant goes to channel 0.
